// File: rtl/capture_spi_reader.sv
// capture_spi_reader
//
// Read-out side of the sample capture buffer. Streams the capture RAM back to the
// host microcontroller in address order as an SPI slave (mode 0, MSB first).
// SCK and CS_N are oversampled in the clk domain; the host must hold each SCK
// phase for at least 4 clk periods.
//
// Optional build macro:
//   CAPTURE_SPI_CHECKSUM_EN - append one trailer byte holding the mod-256 sum of
//                             all DEPTH data bytes; done pulses after the trailer.
//
// Ports:
//   clk        system clock, shared with the capture RAM read port
//   reset      asynchronous active-high reset
//   buf_ready  capture complete / buffer frozen, sampled at cs_n fall only
//   rd_addr    RAM read address
//   rd_data    RAM read data, valid one clk after rd_addr
//   sck        SPI clock from host (asynchronous)
//   cs_n       SPI chip select from host, active low (asynchronous)
//   sdo        SPI serial data to host
//   busy       transfer in progress
//   done       one-cycle pulse after the final bit of the transfer has shifted

module capture_spi_reader #(
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              buf_ready,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    input  logic              sck,
    input  logic              cs_n,
    output logic              sdo,
    output logic              busy,
    output logic              done
);

    // Index of the last data byte, and of the last byte on the wire.
    localparam logic [ADDR_W:0] LastData = (ADDR_W + 1)'(DEPTH - 1);
`ifdef CAPTURE_SPI_CHECKSUM_EN
    localparam logic [ADDR_W:0] LastByte = LastData + 1'b1;
`else
    localparam logic [ADDR_W:0] LastByte = LastData;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StNotRdy,
        StFetch,
        StLoad,
        StShift,
        StTail
    } state_e;

    // ------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sck_prev_q;
    logic                   cs_prev_q;
    logic                   sck_now;
    logic                   cs_now;
    logic                   sck_fall;
    logic                   cs_fall;
    logic                   cs_rise;

    // The cs_n chain resets to the asserted level: if the host keeps cs_n low
    // across a reset, no fall is seen afterwards and the transfer only restarts
    // once the host deselects and selects again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync_q <= '0;
            cs_sync_q  <= '0;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
            cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_now  = sck_sync_q[SYNC_STAGES-1];
    assign cs_now   = cs_sync_q[SYNC_STAGES-1];
    assign sck_fall = sck_prev_q & ~sck_now;
    assign cs_fall  = cs_prev_q & ~cs_now;
    assign cs_rise  = ~cs_prev_q & cs_now;

    // ------------------------------------------------------------------
    // Transfer state
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]        shifter_q, shifter_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [ADDR_W:0]   byte_cnt_q, byte_cnt_d;   // index of the byte in the shifter
    logic              sdo_q, sdo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef CAPTURE_SPI_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rd_addr_q  <= '0;
            shifter_q  <= 8'h00;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= '0;
            sdo_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef CAPTURE_SPI_CHECKSUM_EN
            sum_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            shifter_q  <= shifter_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            sdo_q      <= sdo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef CAPTURE_SPI_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        shifter_d  = shifter_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        sdo_d      = sdo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef CAPTURE_SPI_CHECKSUM_EN
        sum_d      = sum_q;
`endif

        if (cs_rise) begin
            // Deselect aborts from any state and takes priority over a
            // coincident sck fall.
            state_d    = StIdle;
            rd_addr_d  = '0;
            shifter_d  = 8'h00;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = '0;
            sdo_d      = 1'b0;
            busy_d     = 1'b0;
`ifdef CAPTURE_SPI_CHECKSUM_EN
            sum_d      = 8'h00;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    sdo_d     = 1'b0;
                    shifter_d = 8'h00;
                    if (cs_fall) begin
                        if (buf_ready) begin
                            rd_addr_d = '0;
                            busy_d    = 1'b1;
                            state_d   = StFetch;
                        end else begin
                            state_d = StNotRdy;
                        end
                    end
                end

                // Buffer not ready: every byte reads back as 0x00, no RAM access.
                StNotRdy: begin
                    sdo_d     = 1'b0;
                    shifter_d = 8'h00;
                end

                // rd_addr = 0 is presented this cycle; data is valid in StLoad.
                StFetch: begin
                    state_d = StLoad;
                end

                StLoad: begin
                    shifter_d  = rd_data;
                    sdo_d      = rd_data[7];
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = '0;
                    rd_addr_d  = rd_addr_q + 1'b1;   // prefetch byte 1
`ifdef CAPTURE_SPI_CHECKSUM_EN
                    sum_d      = rd_data;
`endif
                    state_d    = StShift;
                end

                StShift: begin
                    if (sck_fall) begin
                        if (bit_cnt_q != 3'd7) begin
                            shifter_d = {shifter_q[6:0], 1'b0};
                            sdo_d     = shifter_q[6];
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end else if (byte_cnt_q != LastByte) begin
                            bit_cnt_d  = 3'd0;
                            byte_cnt_d = byte_cnt_q + 1'b1;
`ifdef CAPTURE_SPI_CHECKSUM_EN
                            if (byte_cnt_q == LastData) begin
                                // Trailer: sum already includes every data byte.
                                shifter_d = sum_q;
                                sdo_d     = sum_q[7];
                            end else begin
                                shifter_d = rd_data;
                                sdo_d     = rd_data[7];
                                rd_addr_d = rd_addr_q + 1'b1;
                                sum_d     = sum_q + rd_data;
                            end
`else
                            // rd_data holds the byte prefetched one byte ago.
                            shifter_d = rd_data;
                            sdo_d     = rd_data[7];
                            rd_addr_d = rd_addr_q + 1'b1;
`endif
                        end else begin
                            bit_cnt_d = 3'd0;
                            shifter_d = 8'h00;
                            sdo_d     = 1'b0;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                            state_d   = StTail;
                        end
                    end
                end

                // Transfer complete: ignore sck until deselect.
                StTail: begin
                    sdo_d = 1'b0;
                end

                default: begin
                    state_d = StIdle;
                    sdo_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign rd_addr = rd_addr_q;
    assign sdo     = sdo_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
